// File: rtl/double_buffer_sequencer.sv
// Block sequencer for a ping-pong double buffer: fills one bank from an
// input stream while the other bank drains to an output stream.
module double_buffer_sequencer #(
  parameter int DATA_WIDTH      = 64,
  parameter int BANK_ADDR_WIDTH = 5,
  parameter int BLOCK_WORDS     = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATA_WIDTH-1:0]      in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_WIDTH-1:0]      out_data,
  output logic                       out_last,
  output logic                       db_switch_banks,
  output logic                       db_wen,
  output logic [BANK_ADDR_WIDTH-1:0] db_wadr,
  output logic [DATA_WIDTH-1:0]      db_wdata,
  output logic                       db_ren,
  output logic [BANK_ADDR_WIDTH-1:0] db_radr,
  input  logic [DATA_WIDTH-1:0]      db_rdata
);

  localparam int CW = $clog2(BLOCK_WORDS + 1);
  localparam int AW = BANK_ADDR_WIDTH;

  localparam logic [CW-1:0] FULL = CW'(BLOCK_WORDS);
  localparam logic [CW-1:0] LAST = CW'(BLOCK_WORDS - 1);

  logic [CW-1:0] wr_cnt;
  logic          wr_full;
  logic [CW-1:0] rd_cnt;
  logic          rd_full;
  logic          inflight;
  logic          inflight_last;

  logic [DATA_WIDTH-1:0] fifo_data [2];
  logic [1:0]            fifo_last;
  logic [1:0]            fifo_cnt;
  logic                  fifo_head;
  logic                  fifo_tail;

  logic       wr_fire;
  logic       pop;
  logic       push;
  logic [2:0] occ;
  logic       room;
  logic       rd_done;
  logic       drained;
  logic       switch_now;

  // Fill side
  assign in_ready = ~wr_full;
  assign wr_fire  = in_valid & ~wr_full;
  assign db_wen   = wr_fire;
  assign db_wdata = wr_fire ? in_data : '0;

  // Drain side
  assign out_valid = fifo_cnt != 2'd0;
  assign pop       = out_valid & out_ready;
  assign push      = inflight;

  // Occupancy after this edge must leave room for the read issued now
  assign occ  = {1'b0, fifo_cnt}
              + {2'b00, inflight}
              - {2'b00, pop};
  assign room = occ < 3'd2;

  assign db_ren = rd_full
                & (rd_cnt < FULL)
                & room;

  assign out_data = fifo_data[fifo_head];
  assign out_last = fifo_last[fifo_head];

  assign rd_done = (rd_cnt == FULL)
                 & ~inflight
                 & (fifo_cnt == 2'd0);
  assign drained = ~rd_full | rd_done;

  assign switch_now      = wr_full & drained;
  assign db_switch_banks = switch_now;

  generate
    if (CW >= AW) begin : g_adr_trunc
      assign db_wadr = wr_cnt[AW-1:0];
      assign db_radr = rd_cnt[AW-1:0];
    end else begin : g_adr_ext
      assign db_wadr = {{(AW-CW){1'b0}}, wr_cnt};
      assign db_radr = {{(AW-CW){1'b0}}, rd_cnt};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_cnt  <= '0;
      wr_full <= 1'b0;
    end else if (switch_now) begin
      wr_cnt  <= '0;
      wr_full <= 1'b0;
    end else if (wr_fire) begin
      wr_cnt <= wr_cnt + 1'b1;
      if (wr_cnt == LAST) begin
        wr_full <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_cnt  <= '0;
      rd_full <= 1'b0;
    end else if (switch_now) begin
      rd_cnt  <= '0;
      rd_full <= 1'b1;
    end else if (db_ren) begin
      rd_cnt <= rd_cnt + 1'b1;
    end
  end

  // Tag the read in flight so its word carries the block-end flag
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
    end else begin
      inflight      <= db_ren;
      inflight_last <= db_ren & (rd_cnt == LAST);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fifo_data[0] <= '0;
      fifo_data[1] <= '0;
      fifo_last    <= '0;
      fifo_tail    <= 1'b0;
    end else if (push) begin
      fifo_data[fifo_tail] <= db_rdata;
      fifo_last[fifo_tail] <= inflight_last;
      fifo_tail            <= ~fifo_tail;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fifo_head <= 1'b0;
    end else if (pop) begin
      fifo_head <= ~fifo_head;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fifo_cnt <= 2'd0;
    end else begin
      fifo_cnt <= fifo_cnt
                + {1'b0, push}
                - {1'b0, pop};
    end
  end

endmodule

// File: doc/double_buffer_sequencer.md
# double_buffer_sequencer

Controller that owns both ports of a `double_buffer` instance and sits between a streaming producer and a streaming consumer. It fills the write bank from a valid/ready input stream in fixed-size blocks. It drains the read bank to a valid/ready output stream, absorbing the buffer's 1-cycle synchronous read latency. It issues `switch_banks` when a full block is ready and the previous block has been fully delivered, so fill and drain overlap and the datapath runs at one word per cycle.

## Interface
- `DATA_WIDTH`, 64, word width; matches the attached double buffer.
- `BANK_ADDR_WIDTH`, 5, bank address width.
- `BLOCK_WORDS`, 32, words per block; 2 ≤ BLOCK_WORDS ≤ 2^BANK_ADDR_WIDTH.

- `clk`  in  1  clock
- `rst_n`  in  1  synchronous, active-low reset
- `in_valid`  in  1  producer word valid
- `in_ready`  out  1  sequencer accepts word
- `in_data`  in  DATA_WIDTH  producer word
- `out_valid`  out  1  consumer word valid
- `out_ready`  in  1  consumer accepts word
- `out_data`  out  DATA_WIDTH  consumer word
- `out_last`  out  1  qualifies the final word of a block
- `db_switch_banks`  out  1  swap read/write banks (1-cycle pulse)
- `db_wen`  out  1  write enable to write bank
- `db_wadr`  out  BANK_ADDR_WIDTH  write address
- `db_wdata`  out  DATA_WIDTH  write data
- `db_ren`  out  1  read enable from read bank
- `db_radr`  out  BANK_ADDR_WIDTH  read address
- `db_rdata`  in  DATA_WIDTH  read data, valid the cycle after `db_ren`

## Operation
- The buffer shares `rst_n`. After reset, the buffer's read/write bank assignment and the sequencer's view of it are coherent.
- State: `wr_cnt` (0..BLOCK_WORDS), `wr_full`, `rd_cnt` (0..BLOCK_WORDS), `rd_full`, `inflight` (1 bit), 2-entry output FIFO with `fifo_cnt` (0..2), and per-entry last flag.
- Fill path:
  - `in_ready = ~wr_full`.
  - On `in_valid & in_ready`: `db_wen=1`, `db_wadr=wr_cnt`, `db_wdata=in_data`, and `wr_cnt++`.
  - When `wr_cnt` reaches BLOCK_WORDS, `wr_full` is set.
- Drain path:
  - `pop = out_valid & out_ready`.
  - `db_ren = rd_full & (rd_cnt < BLOCK_WORDS) & (fifo_cnt + inflight - pop < 2)`.
  - `db_radr = rd_cnt`. On ren, `rd_cnt++` and `inflight` is set for the next cycle.
  - When `inflight`, `db_rdata` is pushed into the FIFO with last = (word index == BLOCK_WORDS-1).
  - FIFO never overflows; push and pop in the same cycle is legal.
- `out_valid = fifo_cnt != 0`. `out_data` and `out_last` come from the FIFO head.
- Drained: `rd_full & rd_cnt==BLOCK_WORDS & ~inflight & fifo_cnt==0`, or `~rd_full`.
- Switch: `db_switch_banks = wr_full & drained`, a single-cycle pulse. On that edge:
  - `wr_cnt←0`, `wr_full←0`
  - `rd_full←1`, `rd_cnt←0`
- No `db_wen` or `db_ren` occurs in a switch cycle: `in_ready` is 0 and `rd_cnt` is exhausted or `rd_full` is 0.
- No partial blocks. A block is switched only when all BLOCK_WORDS words have been written.
- Counter widths: `$clog2(BLOCK_WORDS+1)`. Address outputs are the counters truncated to BANK_ADDR_WIDTH.

## Timing
- Reset values:
  - `in_ready=1`
  - `out_valid=0`, `out_last=0`, `out_data=0`
  - `db_switch_banks=0`, `db_wen=0`, `db_ren=0`
  - all addresses/data 0
  - counters, flags, `inflight` and FIFO cleared
- Reset mid-operation discards all buffered and in-flight words. The first accepted word after reset is written to address 0.
- Outputs `db_wen`, `db_wadr` and `db_wdata` are combinational from the input handshake (zero latency to the buffer).
- Block of N words accepted back-to-back in cycles 0..N-1, with read bank initially empty:
  - switch in cycle N
  - first `db_ren` in cycle N+1
  - first `out_valid` in cycle N+3
- With `out_ready=1` constant, output sustains one word per cycle within a block.
- Filling of block k+1 overlaps draining of block k.
- Backpressure: with `out_ready=0`, at most 2 reads are outstanding (FIFO + inflight). `out_data` is held stable while `out_valid & ~out_ready`.
- Write bank full and read bank not drained: `in_ready` stays 0 until the switch edge. It is 1 again the cycle after the switch.

## Test plan
- Reset, then BLOCK_WORDS=4, inputs 0xA0..0xA3 back-to-back, `out_ready=1` → switch pulse in cycle 4; outputs 0xA0..0xA3 in cycles 7..10; `out_last` only with 0xA3.
- Two blocks streamed continuously (0x10..0x13, 0x20..0x23) → second block fills during first drain; `in_ready` low only while waiting for drain; output order is exact; exactly two switch pulses.
- `out_ready` toggled 1,0,0,1,… during drain → no word lost or duplicated; at most 2 reads outstanding; `out_data` stable while stalled.
- `in_valid` with random gaps, `out_ready=0` until second block is full → `in_ready` drops after 2·BLOCK_WORDS accepted words; no switch occurs until the first block is drained.
- Assert `rst_n=0` while draining word 2 of a block → next cycle all outputs at reset values; a new block 0x30..0x33 then reproduces the first scenario's timing.
- BLOCK_WORDS = 2^BANK_ADDR_WIDTH (e.g. 32, width 5) → addresses 0..31 used; no wrap or overflow of `db_wadr` or `db_radr`.
